// File: rtl/uart_fifo_echo_pkg.sv
// Shared definitions for the UART FIFO echo engine: mode and FSM encodings
// plus the byte transform applied on the RX push path.
package uart_fifo_echo_pkg;

    typedef enum logic [1:0] {
        MODE_ECHO   = 2'b00,
        MODE_TOGGLE = 2'b01,
        MODE_UPPER  = 2'b10,
        MODE_SINK   = 2'b11
    } mode_t;

    typedef enum logic {
        RX_IDLE = 1'b0,
        RX_ACK  = 1'b1
    } rx_state_t;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'b00,
        TX_HOLD1 = 2'b01,
        TX_HOLD2 = 2'b10
    } tx_state_t;

    // ASCII letters differ between cases only in bit 5
    localparam logic [7:0] CASE_BIT = 8'h20;

    function automatic logic is_upper(input logic [7:0] b);
        return (b >= 8'h41) && (b <= 8'h5A);
    endfunction

    function automatic logic is_lower(input logic [7:0] b);
        return (b >= 8'h61) && (b <= 8'h7A);
    endfunction

    // Byte transform for 8-bit data; echo and sink pass the byte unchanged
    function automatic logic [7:0] xform(input mode_t m, input logic [7:0] b);
        logic [7:0] r;
        r = b;
        case (m)
            MODE_TOGGLE: if (is_upper(b) || is_lower(b)) r = b ^ CASE_BIT;
            MODE_UPPER:  if (is_lower(b)) r = b & ~CASE_BIT;
            default:     r = b;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/uart_fifo_echo_if.sv
// Byte handshake between the buart core and the echo engine.
// The buart core is the master (drives RX data and TX busy),
// the echo engine is the slave (strobes reads and writes).
interface uart_fifo_echo_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  rx_valid;
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  uart_rd;
    logic                  tx_busy;
    logic                  uart_wr;
    logic [DATA_WIDTH-1:0] tx_data;

    modport master (
        output rx_valid, rx_data, tx_busy,
        input  uart_rd, uart_wr, tx_data
    );

    modport slave (
        input  rx_valid, rx_data, tx_busy,
        output uart_rd, uart_wr, tx_data
    );
endinterface

// File: rtl/uart_fifo_echo_sync_fifo.sv
// Single-clock FIFO with first-word-fall-through output. Storage has no reset
// and an asynchronous read so it maps onto LUT/distributed RAM; reset only
// clears pointers and the occupancy count, which logically empties it.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // A push into a full FIFO is legal only when the head leaves in the same cycle
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign dout  = mem[rd_ptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    // Storage write
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // Pointers wrap naturally (DEPTH is a power of two); count tracks occupancy exactly
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/uart_fifo_echo.sv
// Buffered echo engine: drains buart RX bytes into a FIFO (optionally
// case-transformed), replays them to buart TX, and reports status.
module uart_fifo_echo
    import uart_fifo_echo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int NUM_LEDS   = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                        clk_96mhz,
    input  logic                        reset,
    uart_fifo_echo_if.slave             bus,
    input  logic [1:0]                  mode,
    input  logic                        clr_ovf,
    output logic [NUM_LEDS-1:0]         led,
    output logic                        overflow,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic [CNT_WIDTH-1:0]        rx_count
);
    rx_state_t rx_state, rx_next;
    tx_state_t tx_state, tx_next;

    logic                  rd_fire;
    logic                  push_req;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  ovf_set;
    logic [DATA_WIDTH-1:0] push_data;
    logic [DATA_WIDTH-1:0] fifo_dout;
    logic [DATA_WIDTH-1:0] tx_hold;

    // Transforms are only meaningful for 8-bit bytes; other widths pass through
    if (DATA_WIDTH == 8) begin : g_xform
        assign push_data = xform(mode_t'(mode), bus.rx_data);
    end else begin : g_pass
        assign push_data = bus.rx_data;
    end

    // Sink mode still reads and counts, it just never stores.
    // A full FIFO accepts a push only if TX pops the head this cycle.
    assign push_req  = rd_fire && (mode_t'(mode) != MODE_SINK);
    assign fifo_push = push_req && (!fifo_full || fifo_pop);
    assign ovf_set   = push_req && fifo_full && !fifo_pop;

    sync_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk_96mhz),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (push_data),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // RX state register
    always_ff @(posedge clk_96mhz) begin
        if (reset) rx_state <= RX_IDLE;
        else       rx_state <= rx_next;
    end

    // RX next state: ACK blanks one cycle because buart clears valid late
    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            RX_IDLE: if (bus.rx_valid) rx_next = RX_ACK;
            RX_ACK:  rx_next = RX_IDLE;
            default: rx_next = RX_IDLE;
        endcase
    end

    // RX outputs: read strobe fires in the same cycle valid is seen in IDLE
    always_comb begin
        rd_fire = 1'b0;
        if (!reset && rx_state == RX_IDLE) rd_fire = bus.rx_valid;
    end

    assign bus.uart_rd = rd_fire;

    // TX state register
    always_ff @(posedge clk_96mhz) begin
        if (reset) tx_state <= TX_IDLE;
        else       tx_state <= tx_next;
    end

    // TX next state: two hold cycles ride out buart's late busy assertion
    always_comb begin
        tx_next = tx_state;
        case (tx_state)
            TX_IDLE:  if (!fifo_empty && !bus.tx_busy) tx_next = TX_HOLD1;
            TX_HOLD1: tx_next = TX_HOLD2;
            TX_HOLD2: tx_next = TX_IDLE;
            default:  tx_next = TX_IDLE;
        endcase
    end

    // TX outputs: pop and write strobe coincide so the byte leaves one cycle after push
    always_comb begin
        fifo_pop = 1'b0;
        if (!reset && tx_state == TX_IDLE) fifo_pop = !fifo_empty && !bus.tx_busy;
    end

    // tx_data shows the head during the strobe, then the held copy until the next pop
    assign bus.uart_wr = fifo_pop;
    assign bus.tx_data = fifo_pop ? fifo_dout : tx_hold;

    // Status registers: LEDs, RX counter, sticky overflow (set beats clear), TX hold
    always_ff @(posedge clk_96mhz) begin
        if (reset) begin
            led      <= '0;
            rx_count <= '0;
            overflow <= 1'b0;
            tx_hold  <= '0;
        end else begin
            if (rd_fire) begin
                rx_count <= rx_count + CNT_WIDTH'(1);
                led      <= bus.rx_data[NUM_LEDS-1:0];
            end
            if (ovf_set)      overflow <= 1'b1;
            else if (clr_ovf) overflow <= 1'b0;
            if (fifo_pop) tx_hold <= fifo_dout;
        end
    end
endmodule
